puf_chal_seq: RTL and testbench

Parametrised challenge sequencer for the read-write-collision PUF, replacing the fixed 31-challenge top-level FSM. It sits between the system controller and the RWC generator (`rwc_ctrl`). It issues a configurable burst of challenges, stepping the address each time, and waits for each generator response with a timeout. Each response is returned over a valid/ready stream, and after each burst the sequencer rests for a configurable interval, then either stops or repeats.

---
 rtl/puf_chal_seq.sv | 213 +++++++++++++++++++++
 tb/tb_puf_chal_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_chal_seq.sv
// Challenge sequencer for the RWC PUF: issues bursts of challenges to
// rwc_ctrl, collects responses with timeout, streams them out, rests.
//
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   start, abort, cont     : control (start/cont latched in IDLE)
//   chal_data, chal_addr   : challenge data / base address
//   gen_enable/data/addr   : launch interface to the generator
//   gen_available,
//   gen_rsp_pos/neg        : generator response
//   rsp_valid/ready/data,
//   rsp_idx, rsp_timeout   : response stream
//   busy, done, err_cnt    : status
module puf_chal_seq #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int NUM_CHAL    = 31,
  parameter int ADDR_STEP   = 1,
  parameter int TIMEOUT     = 1024,
  parameter int REST_CYCLES = 150_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic [DATA_W-1:0]   chal_data,
  input  logic [ADDR_W-1:0]   chal_addr,
  output logic                gen_enable,
  output logic [DATA_W-1:0]   gen_data,
  output logic [ADDR_W-1:0]   gen_addr,
  input  logic                gen_available,
  input  logic [DATA_W-1:0]   gen_rsp_pos,
  input  logic [DATA_W-1:0]   gen_rsp_neg,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic [15:0]         rsp_idx,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int RW =
    (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] REST_LAST = RW'(REST_CYCLES - 1);
  localparam logic [15:0] IDX_LAST = 16'(NUM_CHAL - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT,
    REST
  } state_t;

  state_t state_q, state_d;

  logic                cont_q, cont_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         idx_q, idx_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [RW-1:0]       rest_q, rest_d;
  logic [2*DATA_W-1:0] rdat_q, rdat_d;
  logic                rtmo_q, rtmo_d;
  logic [15:0]         err_q, err_d;
  logic                en_q, en_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cont_q  <= 1'b0;
      data_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      rest_q  <= '0;
      rdat_q  <= '0;
      rtmo_q  <= 1'b0;
      err_q   <= '0;
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      data_q  <= data_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      rest_q  <= rest_d;
      rdat_q  <= rdat_d;
      rtmo_q  <= rtmo_d;
      err_q   <= err_d;
      en_q    <= en_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    data_d  = data_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    rest_d  = rest_q;
    rdat_d  = rdat_q;
    rtmo_d  = rtmo_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cont_d  = cont;
          data_d  = chal_data;
          base_d  = chal_addr;
          addr_d  = chal_addr;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // a response in the last timeout cycle still wins
        if (gen_available) begin
          rdat_d  = {gen_rsp_neg, gen_rsp_pos};
          rtmo_d  = 1'b0;
          state_d = OUT;
        end else if (tmo_q == TMO_LAST) begin
          rdat_d  = '0;
          rtmo_d  = 1'b1;
          if (err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
          state_d = OUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      OUT: begin
        if (rsp_ready) begin
          if (idx_q == IDX_LAST) begin
            rest_d  = '0;
            state_d = REST;
          end else begin
            idx_d   = idx_q + 16'd1;
            addr_d  = addr_q + STEP;
            state_d = ISSUE;
          end
        end
      end
      REST: begin
        if (rest_q == REST_LAST) begin
          if (cont_q) begin
            idx_d   = '0;
            addr_d  = base_q;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rest_d = rest_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      err_d   = err_q;
    end
  end

  // outputs are registered from the next state so they line up
  // with the state they describe
  always_comb begin
    en_d   = (state_d == ISSUE);
    vld_d  = (state_d == OUT);
    busy_d = (state_d != IDLE);
    done_d = (state_d == REST) && (rest_d == REST_LAST);
  end

  assign gen_enable  = en_q;
  assign gen_data    = data_q;
  assign gen_addr    = addr_q;
  assign rsp_valid   = vld_q;
  assign rsp_data    = rdat_q;
  assign rsp_idx     = idx_q;
  assign rsp_timeout = rtmo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_puf_chal_seq.sv
// Directed testbench for puf_chal_seq: bursts, backpressure, timeout,
// coincident response/timeout, continuous mode, abort, reset.
module tb_puf_chal_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        abort;
  logic        cont;
  logic [31:0] chal_data;
  logic [9:0]  chal_addr;
  logic        gen_enable;
  logic [31:0] gen_data;
  logic [9:0]  gen_addr;
  logic        gen_available;
  logic [31:0] gen_rsp_pos;
  logic [31:0] gen_rsp_neg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [15:0] rsp_idx;
  logic        rsp_timeout;
  logic        busy;
  logic        done;
  logic [15:0] err_cnt;

  int errs = 0;
  int checks = 0;

  puf_chal_seq #(
    .DATA_W(32),
    .ADDR_W(10),
    .NUM_CHAL(4),
    .ADDR_STEP(1),
    .TIMEOUT(8),
    .REST_CYCLES(5)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .abort(abort),
    .cont(cont),
    .chal_data(chal_data),
    .chal_addr(chal_addr),
    .gen_enable(gen_enable),
    .gen_data(gen_data),
    .gen_addr(gen_addr),
    .gen_available(gen_available),
    .gen_rsp_pos(gen_rsp_pos),
    .gen_rsp_neg(gen_rsp_neg),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_idx(rsp_idx),
    .rsp_timeout(rsp_timeout),
    .busy(busy),
    .done(done),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"}, 64'(gen_enable), 64'd0);
    chk({tag, "_vld"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tmo"}, 64'(rsp_timeout), 64'd0);
    chk({tag, "_rdat"}, rsp_data, 64'd0);
    chk({tag, "_idx"}, 64'(rsp_idx), 64'd0);
    chk({tag, "_gdat"}, 64'(gen_data), 64'd0);
    chk({tag, "_gadr"}, 64'(gen_addr), 64'd0);
    chk({tag, "_err"}, 64'(err_cnt), 64'd0);
  endtask

  // Entered in the launch cycle; returns in the OUT cycle.
  // Generator answers dl cycles after the launch cycle.
  task automatic do_chal(input logic [15:0] i,
                         input logic [9:0] a,
                         input logic [31:0] p,
                         input logic [31:0] n,
                         input int dl);
    chk("launch", 64'(gen_enable), 64'd1);
    chk("addr", 64'(gen_addr), 64'(a));
    for (int k = 1; k <= dl; k++) begin
      tick();
      if (k == 1)
        chk("en_pulse", 64'(gen_enable), 64'd0);
      gen_available = (k == dl);
      gen_rsp_pos = (k == dl) ? p : 32'hDEAD_BEEF;
      gen_rsp_neg = (k == dl) ? n : 32'hBAD0_F00D;
    end
    tick();
    gen_available = 1'b0;
    chk("out_vld", 64'(rsp_valid), 64'd1);
    chk("out_data", rsp_data, {n, p});
    chk("out_idx", 64'(rsp_idx), 64'(i));
    chk("out_tmo", 64'(rsp_timeout), 64'd0);
  endtask

  task automatic burst4(input logic [9:0] base,
                        input logic [31:0] seed,
                        input int dl);
    logic [9:0] a;
    for (int i = 0; i < 4; i++) begin
      a = base + 10'(i);
      do_chal(16'(i), a, seed + 32'(i), ~(seed + 32'(i)), dl);
      tick();
    end
  endtask

  // Entered in the first REST cycle; returns in the done cycle.
  task automatic rest_end();
    tick();
    tick();
    tick();
    chk("rest_nodone", 64'(done), 64'd0);
    tick();
    chk("done", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cont = 1'b0;
    chal_data = '0;
    chal_addr = '0;
    gen_available = 1'b0;
    gen_rsp_pos = '0;
    gen_rsp_neg = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk_reset("rst");

    // single burst with address wrap
    resetn = 1'b1;
    start = 1'b1;
    chal_data = 32'hA5A5_0001;
    chal_addr = 10'h3FE;
    rsp_ready = 1'b1;
    tick();
    start = 1'b0;
    chal_data = 32'h0;
    chk("gdat1", 64'(gen_data), 64'hA5A5_0001);
    chk("busy1", 64'(busy), 64'd1);
    burst4(10'h3FE, 32'h1111_0000, 2);
    rest_end();
    tick();
    chk("idle1_busy", 64'(busy), 64'd0);
    chk("idle1_done", 64'(done), 64'd0);

    // backpressure then timeout on challenge 2
    start = 1'b1;
    chal_data = 32'h1234_5678;
    chal_addr = 10'h010;
    rsp_ready = 1'b0;
    tick();
    start = 1'b0;
    do_chal(16'd0, 10'h010, 32'h2222_0000, 32'h3333_0000, 1);
    gen_available = 1'b1;
    gen_rsp_pos = 32'hFFFF_FFFF;
    gen_rsp_neg = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_vld", 64'(rsp_valid), 64'd1);
      chk("bp_data", rsp_data, 64'h3333_0000_2222_0000);
      chk("bp_en", 64'(gen_enable), 64'd0);
    end
    gen_available = 1'b0;
    rsp_ready = 1'b1;
    tick();
    do_chal(16'd1, 10'h011, 32'h2222_0001, 32'h3333_0001, 1);
    tick();
    chk("to_launch", 64'(gen_enable), 64'd1);
    chk("to_addr", 64'(gen_addr), 64'h012);
    for (int c = 0; c < 8; c++) tick();
    chk("to_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("to_vld", 64'(rsp_valid), 64'd1);
    chk("to_data", rsp_data, 64'd0);
    chk("to_flag", 64'(rsp_timeout), 64'd1);
    chk("to_idx", 64'(rsp_idx), 64'd2);
    chk("to_err", 64'(err_cnt), 64'd1);
    tick();
    do_chal(16'd3, 10'h013, 32'h2222_0003, 32'h3333_0003, 1);
    tick();
    rest_end();
    tick();
    chk("idle2_busy", 64'(busy), 64'd0);

    // response in the last timeout cycle, then abort in OUT
    start = 1'b1;
    chal_data = 32'h0000_0100;
    chal_addr = 10'h100;
    tick();
    start = 1'b0;
    do_chal(16'd0, 10'h100, 32'h4444_4444, 32'h5555_5555, 8);
    chk("sim_err", 64'(err_cnt), 64'd1);
    abort = 1'b1;
    rsp_ready = 1'b0;
    tick();
    abort = 1'b0;
    rsp_ready = 1'b1;
    chk("ab1_busy", 64'(busy), 64'd0);
    chk("ab1_vld", 64'(rsp_valid), 64'd0);
    chk("ab1_en", 64'(gen_enable), 64'd0);

    // continuous mode, abort in second burst
    start = 1'b1;
    cont = 1'b1;
    chal_data = 32'h0000_0200;
    chal_addr = 10'h200;
    tick();
    start = 1'b0;
    cont = 1'b0;
    burst4(10'h200, 32'h6666_0000, 1);
    rest_end();
    tick();
    do_chal(16'd0, 10'h200, 32'h7777_0000, 32'h8888_0000, 1);
    chk("c2_gdat", 64'(gen_data), 64'h200);
    tick();
    chk("c2_launch", 64'(gen_enable), 64'd1);
    chk("c2_addr", 64'(gen_addr), 64'h201);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab2_busy", 64'(busy), 64'd0);
    chk("ab2_vld", 64'(rsp_valid), 64'd0);
    chk("ab2_en", 64'(gen_enable), 64'd0);
    chk("ab2_done", 64'(done), 64'd0);
    tick();
    chk("ab2_idle", 64'(busy), 64'd0);
    chk("ab2_err", 64'(err_cnt), 64'd1);

    // reset during WAIT, then a clean burst
    start = 1'b1;
    chal_data = 32'h0BAD_CAFE;
    chal_addr = 10'h055;
    tick();
    start = 1'b0;
    chk("r_launch", 64'(gen_enable), 64'd1);
    tick();
    resetn = 1'b0;
    tick();
    chk_reset("midrst");
    resetn = 1'b1;
    start = 1'b1;
    chal_data = 32'h0000_0077;
    chal_addr = 10'h001;
    tick();
    start = 1'b0;
    burst4(10'h001, 32'h9999_0000, 1);
    rest_end();
    tick();
    chk("fin_busy", 64'(busy), 64'd0);
    chk("fin_err", 64'(err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
